// File: rtl/finv_nr.sv
// finv_nr: IEEE-754 single-precision reciprocal (table seed + Newton-Raphson, round, pack).
// Define FINV_RNE_EN for round-to-nearest-even packing; otherwise the mantissa is truncated.
module finv_nr #(
  parameter int LUT_BITS = 12,
  parameter int NR_ITERS = 1,
  parameter int FRAC_W   = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  // Handshake: a transfer happens on any rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and y is stable while out_valid waits.
  localparam int         F     = FRAC_W;
  localparam int         TAB_N = 1 << LUT_BITS;
  localparam logic [1:0] ITERS = 2'(NR_ITERS);
  localparam logic [F+1:0] TWO = {2'b10, {F{1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    PACK = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Seed holds ~2/d in Q1.F, i.e. twice the reciprocal, so every mantissa lands in (1,2].
  function automatic logic [F:0] seed_entry(input int i);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'd1 << (F + LUT_BITS + 2);
    den = (64'd1 << (LUT_BITS + 1)) + 64'(2 * i + 1);
    return (F+1)'(num / den);
  endfunction

  logic [F:0] seed_tab [TAB_N];
  for (genvar g = 0; g < TAB_N; g++) begin : g_seed
    assign seed_tab[g] = seed_entry(g);
  end

  logic         s_r;
  logic [7:0]   e_r;
  logic [22:0]  m_r;
  logic [F:0]   yw_r;
  logic [F+1:0] t_r;
  logic [1:0]   itr_r;
  logic [1:0]   itr_inc;
  logic [F:0]   d;

  assign d       = {1'b1, m_r, {(F-23){1'b0}}};
  assign itr_inc = itr_r + 2'd1;

  // One shared multiplier: d*y in MUL1, y*t in MUL2.
  logic [F+1:0]   mul_a;
  logic [F+1:0]   mul_b;
  logic [2*F+3:0] prod;
  logic [F+1:0]   t_nxt;
  logic [F:0]     y_mul;

  assign mul_a = (state == MUL2) ? {1'b0, yw_r} : {1'b0, d};
  assign mul_b = (state == MUL2) ? t_r : {1'b0, yw_r};
  assign prod  = {{(F+2){1'b0}}, mul_a} * {{(F+2){1'b0}}, mul_b};
  // y carries 2/d, so d*y is halved before forming the correction term 2 - d*(y/2).
  assign t_nxt = TWO - prod[2*F+2:F+1];
  assign y_mul = prod[2*F:F];

  logic        y_msb;
  logic [F:0]  y_norm;
  logic [22:0] mant_raw;
  logic        round_up;
  logic [23:0] mant_sum;
  logic [9:0]  exp_n;
  logic [7:0]  exp_z;
  logic        m_zero;
  logic [31:0] packed_y;

  assign y_msb    = yw_r[F];
  assign y_norm   = y_msb ? yw_r : {yw_r[F-1:0], 1'b0};
  assign mant_raw = y_norm[F-1 -: 23];

`ifdef FINV_RNE_EN
  logic guard;
  logic sticky;
  assign guard    = y_norm[F-24];
  assign sticky   = |y_norm[F-25:0];
  assign round_up = guard & (sticky | mant_raw[0]);
`else
  logic unused_rnd;
  assign unused_rnd = ^y_norm[F-24:0];
  assign round_up   = 1'b0;
`endif

  assign mant_sum = {1'b0, mant_raw} + {23'd0, round_up};
  assign exp_n    = 10'd253 - {2'b00, e_r} - {9'd0, ~y_msb} + {9'd0, mant_sum[23]};
  assign exp_z    = 8'd254 - e_r;
  assign m_zero   = (m_r == 23'd0);

  logic unused_bits;
  assign unused_bits = ^{prod[2*F+3], prod[F-1:0], y_norm[F], exp_n[8]};

  always_comb begin
    packed_y = {s_r, exp_n[7:0], mant_sum[22:0]};
    if (e_r == 8'd0) begin
      packed_y = {s_r, 8'hFF, 23'd0};
    end else if (e_r == 8'hFF) begin
      packed_y = m_zero ? {s_r, 31'd0} : 32'h7FC0_0000;
    end else if (m_zero) begin
      // Power-of-two input: exact 2.0, bypass the iterated value.
      packed_y = (exp_z == 8'd0) ? {s_r, 31'd0} : {s_r, exp_z, 23'd0};
    end else if (exp_n[9] || (exp_n == 10'd0)) begin
      packed_y = {s_r, 31'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Accept cycle to first out_valid cycle: 3 + 2*NR_ITERS, independent of operand.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEED;
      end
      SEED: state_nxt = (NR_ITERS == 0) ? PACK : MUL1;
      MUL1: state_nxt = MUL2;
      MUL2: state_nxt = (itr_inc == ITERS) ? PACK : MUL1;
      PACK: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r   <= 1'b0;
      e_r   <= 8'd0;
      m_r   <= 23'd0;
      yw_r  <= '0;
      t_r   <= '0;
      itr_r <= 2'd0;
      y     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_r   <= x[31];
            e_r   <= x[30:23];
            m_r   <= x[22:0];
            itr_r <= 2'd0;
          end
        end
        SEED: yw_r <= seed_tab[m_r[22 -: LUT_BITS]];
        MUL1: t_r  <= t_nxt;
        MUL2: begin
          yw_r  <= y_mul;
          itr_r <= itr_inc;
        end
        PACK:    y <= packed_y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_finv_nr.sv
// tb_finv_nr: directed + random checks of finv_nr against an exact integer reciprocal model.
module tb_finv_nr;

  localparam int NR  = 1;
  localparam int LAT = 3 + 2 * NR;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_y;

  finv_nr #(.LUT_BITS(12), .NR_ITERS(NR), .FRAC_W(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Correctly rounded 1/x: mantissa = round(2^47 / (2^23 + m)), exponent 253 - e.
  function automatic logic [31:0] ref_inv(input logic [31:0] xv);
    logic        s;
    int          e;
    int          ex;
    longint      dv;
    longint      q;
    longint      r;
    longint      one47;
    logic [31:0] res;
    s = xv[31];
    e = int'(xv[30:23]);
    one47 = 64'h0000_8000_0000_0000;
    if (e == 0) begin
      res = {s, 8'hFF, 23'h0};
    end else if (e == 255) begin
      res = (xv[22:0] == 23'd0) ? {s, 31'h0} : 32'h7FC0_0000;
    end else begin
      dv = 64'd8388608 + longint'(xv[22:0]);
      q  = one47 / dv;
      r  = one47 % dv;
      ex = 253 - e;
      if (2 * r > dv) q = q + 1;
      if (q == 64'd16777216) begin
        q  = 64'd8388608;
        ex = ex + 1;
      end
      if (ex <= 0) res = {s, 31'h0};
      else         res = {s, ex[7:0], q[22:0]};
    end
    return res;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic check_ulp(input string tag, input logic [31:0] got, input logic [31:0] expv,
                           input int tol);
    logic [31:0] diff;
    logic        ok;
    diff = (got[30:0] > expv[30:0]) ? {1'b0, got[30:0] - expv[30:0]}
                                    : {1'b0, expv[30:0] - got[30:0]};
    ok = (got[31] === expv[31]) && (diff <= 32'(tol));
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %h expected %h within %0d ulp", tag, got, expv, tol);
    end
  endtask

  // driver: one full transaction, called and returning at a negedge, out_ready held high
  task automatic do_op(input logic [31:0] xv, input logic [31:0] expv, input int tol,
                       input string tag);
    int          k;
    int          lat;
    logic [31:0] e;
    exp_q.push_back(expv);
    in_valid = 1'b1;
    x        = xv;
    k        = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, " accept"}, {31'd0, in_ready}, 32'd1);
    if (in_ready !== 1'b1) begin
      in_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(LAT));
    if (out_valid !== 1'b1) begin
      void'(exp_q.pop_front());
      return;
    end
    e      = exp_q.pop_front();
    last_y = y;
    check_ulp(tag, y, e, tol);
    @(negedge clk);
    check_eq({tag, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] xv;
    int          k;
    int          stale;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 32'd0;
    last_y    = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset flags", {30'd0, out_valid, in_ready}, 32'd1);
    check_eq("reset y", y, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed values and specials
    do_op(32'h3F80_0000, 32'h3F80_0000, 0, "one");
    do_op(32'h4000_0000, 32'h3F00_0000, 0, "two");
    do_op(32'hC080_0000, 32'hBE80_0000, 0, "neg4");
    do_op(32'h3F00_0000, 32'h4000_0000, 0, "half");
`ifdef FINV_RNE_EN
    do_op(32'h4040_0000, 32'h3EAA_AAAB, 0, "three");
`else
    do_op(32'h4040_0000, 32'h3EAA_AAAB, 1, "three");
    check_eq("three trunc", {31'd0, (last_y === 32'h3EAA_AAAA) || (last_y === 32'h3EAA_AAAB)},
             32'd1);
`endif
    do_op(32'h0000_0000, 32'h7F80_0000, 0, "zero");
    do_op(32'h8000_0001, 32'hFF80_0000, 0, "neg denorm");
    do_op(32'h7F80_0000, 32'h0000_0000, 0, "inf");
    do_op(32'hFF80_0000, 32'h8000_0000, 0, "neg inf");
    do_op(32'h7F7F_FFFF, 32'h0000_0000, 0, "max normal");
    do_op(32'h7FC0_0001, 32'h7FC0_0000, 0, "nan");
    do_op(32'h7E80_0000, 32'h0080_0000, 0, "min result");
    do_op(32'h7E80_0001, 32'h0000_0000, 0, "underflow");
    do_op(32'h3FFF_FFFF, ref_inv(32'h3FFF_FFFF), 1, "mant ones");

    // backpressure: result must hold, and a held in_valid must not be taken
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 32'h4000_0000;
    @(negedge clk);
    x = 32'h4080_0000;
    k = 1;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("bp latency", 32'(k), 32'(LAT));
    for (int i = 0; i < 7; i++) begin
      check_eq("bp y", y, 32'h3F00_0000);
      check_eq("bp flags", {30'd0, out_valid, in_ready}, 32'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp release", {30'd0, out_valid, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);

    // reset during MUL1 with in_valid held
    in_valid = 1'b1;
    x        = 32'h4040_0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst flags", {30'd0, out_valid, in_ready}, 32'd1);
    check_eq("rst y", y, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    stale    = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || y !== 32'd0) stale++;
    end
    check_eq("no stale result", 32'(stale), 32'd0);
    do_op(32'h40A0_0000, ref_inv(32'h40A0_0000), 1, "after rst");

    // random normals against the exact model
    for (int i = 0; i < 4000; i++) begin
      xv = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 252)), 23'($urandom)};
      do_op(xv, ref_inv(xv), 1, $sformatf("rand%0d x=%h", i, xv));
    end

    check_eq("queue empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
